// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with debounce and one code per press.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat pulses while a key stays held.
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_in,
  output logic [3:0] cols_out,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  // Nibble index is {row, col}: rows top-to-bottom, columns left-to-right.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [3:0]      rs_meta_q, rs_q;
  logic [3:0]      cols_q, cols_d;
  logic [3:0]      row_q, row_d;
  logic [DW-1:0]   dcnt_q, dcnt_d, dcnt_inc;
  logic [DW-1:0]   rcnt_q, rcnt_d, rcnt_inc;
  logic [3:0]      key_q, key_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            tick, onehot, accept;
  logic [3:0]      rot;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0]   rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + RW'(1);
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_TICKS > 0);
`endif

  function automatic logic [3:0] key_code(input logic [3:0] col, input logic [3:0] row);
    logic [1:0] ci, ri;
    ci = col[3] ? 2'd3 : col[2] ? 2'd2 : col[1] ? 2'd1 : 2'd0;
    ri = row[3] ? 2'd3 : row[2] ? 2'd2 : row[1] ? 2'd1 : 2'd0;
    return KEYMAP[{ri, ci, 2'b00} +: 4];
  endfunction

  assign tick     = (div_q == CW'(CLK_DIV - 1));
  assign div_d    = tick ? '0 : div_q + CW'(1);
  assign onehot   = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
  assign rot      = {cols_q[2:0], cols_q[3]};
  assign dcnt_inc = dcnt_q + DW'(1);
  assign rcnt_inc = rcnt_q + DW'(1);

  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    key_d   = key_q;
    held_d  = held_q;
    valid_d = 1'b0;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          // Zero or multiple rows (ghosting) both just move on to the next column.
          if (onehot) begin
            row_d  = rs_q;
            dcnt_d = DW'(1);
            if (DEBOUNCE_TICKS == 1) accept = 1'b1;
            else state_d = DEBOUNCE;
          end else begin
            cols_d = rot;
          end
        end
        DEBOUNCE: begin
          if (rs_q == row_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DW'(DEBOUNCE_TICKS)) accept = 1'b1;
          end else begin
            dcnt_d  = '0;
            cols_d  = rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (rs_q == 4'd0) begin
            rcnt_d = rcnt_inc;
`ifdef KEYPAD_REPEAT_EN
            rep_d  = '0;
`endif
            if (rcnt_inc == DW'(DEBOUNCE_TICKS)) begin
              held_d  = 1'b0;
              cols_d  = rot;
              state_d = SCAN;
            end
          end else begin
            rcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d  = rep_inc;
            if (rep_inc == RW'(REPEAT_TICKS)) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (accept) begin
      key_d   = key_code(cols_q, row_d);
      valid_d = 1'b1;
      held_d  = 1'b1;
      rcnt_d  = '0;
      state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      div_q     <= '0;
      rs_meta_q <= 4'd0;
      rs_q      <= 4'd0;
      cols_q    <= 4'b0001;
      row_q     <= 4'd0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rs_meta_q <= rows_in;
      rs_q      <= rs_meta_q;
      cols_q    <= cols_d;
      row_q     <= row_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign cols_out  = cols_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner (CLK_DIV=4, DEBOUNCE_TICKS=3).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [3:0] press_col = 4'b0000;
  logic [3:0] press_row = 4'b0000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npulse = 0;
  logic [3:0] last_key = 4'h0;

  keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
    .clk(clk), .reset(reset), .rows_in(rows_in), .cols_out(cols_out),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: the pressed key connects its column drive to its row line.
  assign rows_in = (cols_out == press_col) ? press_row : 4'b0000;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      npulse   <= npulse + 1;
      last_key <= key;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic to_edge(input int n);
    while (cyc < n) nstep();
  endtask

  task automatic wait_cols(input logic [3:0] val, input string tag);
    int n;
    n = 0;
    while (cols_out == val && n < 64) begin nstep(); n++; end
    while (cols_out != val && n < 128) begin nstep(); n++; end
    if (cols_out != val) timeout(tag);
  endtask

  task automatic press_key(input logic [3:0] c, input logic [3:0] r, input logic [3:0] k, input string tag);
    int base, n;
    base = npulse;
    press_col = c;
    press_row = r;
    n = 0;
    while (npulse == base && n < 200) begin nstep(); n++; end
    if (npulse == base) timeout({tag, "_press"});
    else begin
      check({tag, "_key"}, key, k);
      check({tag, "_held"}, key_held, 1'b1);
    end
    press_row = 4'b0000;
    n = 0;
    while (key_held && n < 200) begin nstep(); n++; end
    if (key_held) timeout({tag, "_release"});
    nstep();
    check({tag, "_pulses"}, npulse - base, 1);
  endtask

  initial begin
    int base, e, a;
    reset = 1'b1;
    repeat (3) nstep();
    check("rst_cols", cols_out, 4'b0001);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b0;

    to_edge(3);  check("rot_e3", cols_out, 4'b0001);
    to_edge(4);  check("rot_e4", cols_out, 4'b0010);
    to_edge(7);  check("rot_e7", cols_out, 4'b0010);
    to_edge(8);  check("rot_e8", cols_out, 4'b0100);
    to_edge(12); check("rot_e12", cols_out, 4'b1000);
    to_edge(16); check("rot_e16", cols_out, 4'b0001);

    // Key 2: column 0010 driven at edge 20, detected at tick 24, accepted at tick 32.
    base = npulse;
    press_col = 4'b0010;
    press_row = 4'b0001;
    to_edge(24); check("k2_hold_col", cols_out, 4'b0010);
    to_edge(31); check("k2_valid_e31", key_valid, 1'b0);
    to_edge(32);
    check("k2_valid_e32", key_valid, 1'b1);
    check("k2_key", key, 4'h2);
    check("k2_held", key_held, 1'b1);
    to_edge(33); check("k2_valid_e33", key_valid, 1'b0);
    press_row = 4'b0000;
    to_edge(43); check("k2_held_e43", key_held, 1'b1);
    to_edge(44);
    check("k2_held_e44", key_held, 1'b0);
    check("k2_cols_e44", cols_out, 4'b0100);
    check("k2_key_kept", key, 4'h2);
    to_edge(50); check("k2_pulses", npulse - base, 1);

    press_key(4'b1000, 4'b1000, 4'hD, "kD");
    press_key(4'b0001, 4'b1000, 4'hE, "kE");
    press_key(4'b0100, 4'b0010, 4'h6, "k6");

    // Bounce: row 0100 seen for a single tick on column 0001.
    base = npulse;
    press_col = 4'b0001;
    press_row = 4'b0000;
    wait_cols(4'b0001, "bounce_cols");
    e = cyc;
    press_row = 4'b0100;
    to_edge(e + 4); check("bounce_col_hold", cols_out, 4'b0001);
    press_row = 4'b0000;
    to_edge(e + 8);
    check("bounce_rotate", cols_out, 4'b0010);
    check("bounce_pulses", npulse - base, 0);
    press_key(4'b0001, 4'b0100, 4'h7, "k7");

    // Ghost: two rows on one column must not stall the scan.
    base = npulse;
    press_col = 4'b0010;
    press_row = 4'b0011;
    wait_cols(4'b0010, "ghost_cols");
    e = cyc;
    to_edge(e + 4); check("ghost_rotate", cols_out, 4'b0100);
    to_edge(e + 44);
    check("ghost_pulses", npulse - base, 0);
    check("ghost_held", key_held, 1'b0);
    press_row = 4'b0000;

    // Key 5 held for 20 ticks after acceptance.
    base = npulse;
    press_col = 4'b0010;
    press_row = 4'b0010;
    a = 0;
    while (npulse == base && a < 200) begin nstep(); a++; end
    if (npulse == base) timeout("k5_press");
    a = cyc;
    check("k5_key", key, 4'h5);
    to_edge(a + 81);
`ifdef KEYPAD_REPEAT_EN
    check("k5_pulses", npulse - base, 5);
`else
    check("k5_pulses", npulse - base, 1);
`endif
    check("k5_last_key", last_key, 4'h5);
    check("k5_held", key_held, 1'b1);

    // Reset while HELD.
    base = npulse;
    reset = 1'b1;
    nstep();
    check("hrst_cols", cols_out, 4'b0001);
    check("hrst_key", key, 4'h0);
    check("hrst_valid", key_valid, 1'b0);
    check("hrst_held", key_held, 1'b0);
    press_row = 4'b0000;
    repeat (2) nstep();
    check("hrst_pulses", npulse - base, 0);
    reset = 1'b0;
    repeat (2) nstep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
